// File: rtl/fp_norm_round.sv
// Normalise-and-round tail stage of the FPU datapath.
// Takes an unnormalised magnitude/exponent/sign, moves the leading one to
// NORM_POS, rounds to nearest-even and packs an IEEE-754 double with flags.
// Three registered stages (detect, shift, round/pack) behind a valid/ready
// handshake; one result per cycle under continuous flow.
module fp_norm_round #(
    parameter int unsigned MAG_WIDTH    = 64,
    parameter int unsigned INDEX_MAX    = 11,
    parameter int unsigned EXP_IN_WIDTH = 13,
    parameter int unsigned EXP_WIDTH    = 11,
    parameter int unsigned FRAC_WIDTH   = 52,
    parameter int unsigned NORM_POS     = 62
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_sign,
    input  logic [EXP_IN_WIDTH-1:0]           in_exp,
    input  logic [MAG_WIDTH-1:0]              in_mag,
    input  logic                              in_sticky,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]     out_result,
    output logic                              out_overflow,
    output logic                              out_underflow,
    output logic                              out_inexact
);

    // Internal exponent is one bit wider than the input so in_exp + L - NORM_POS
    // never wraps.
    localparam int unsigned EW       = EXP_IN_WIDTH + 1;
    localparam int unsigned RW       = EXP_WIDTH + FRAC_WIDTH + 1;
    localparam int unsigned GuardPos = NORM_POS - FRAC_WIDTH - 1;

    localparam logic [INDEX_MAX-1:0] NormIdx = INDEX_MAX'(NORM_POS);
    localparam logic [EW-1:0]        NormExp = EW'(NORM_POS);
    localparam logic [EW-1:0]        ExpMax  = EW'((1 << EXP_WIDTH) - 1);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q, s2_valid_q, s3_valid_q;
    logic s1_adv, s2_adv, s3_adv;

    // A stage advances when its successor is empty or itself advancing.
    always_comb begin
        s3_adv   = out_ready;
        s2_adv   = !s3_valid_q || s3_adv;
        s1_adv   = !s2_valid_q || s2_adv;
        in_ready = !s1_valid_q || s1_adv;
    end

    // ------------------------------------------------------------------
    // Stage 1: leading-one detect
    // ------------------------------------------------------------------
    logic [INDEX_MAX-1:0]    lead_idx;
    logic                    in_zero;

    logic                    s1_sign_q;
    logic [EXP_IN_WIDTH-1:0] s1_exp_q;
    logic [MAG_WIDTH-1:0]    s1_mag_q;
    logic                    s1_sticky_q;
    logic [INDEX_MAX-1:0]    s1_lead_q;
    logic                    s1_zero_q;

    // Highest set bit wins; an all-zero magnitude reports index 0.
    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < int'(MAG_WIDTH); i++) begin
            if (in_mag[i]) begin
                lead_idx = INDEX_MAX'(i);
            end
        end
        in_zero = (in_mag == '0);
    end

    // Stage 1 valid register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
        end
    end

    // Stage 1 payload, captured on an input transfer.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_sign_q   <= in_sign;
            s1_exp_q    <= in_exp;
            s1_mag_q    <= in_mag;
            s1_sticky_q <= in_sticky;
            s1_lead_q   <= lead_idx;
            s1_zero_q   <= in_zero;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: normalising shift and exponent adjust
    // ------------------------------------------------------------------
    logic [INDEX_MAX-1:0] shamt;
    logic [MAG_WIDTH-1:0] norm_mag;
    logic                 norm_sticky;
    logic [EW-1:0]        norm_exp;

    logic                 s2_sign_q;
    logic [EW-1:0]        s2_exp_q;
    logic [MAG_WIDTH-1:0] s2_mag_q;
    logic                 s2_sticky_q;
    logic                 s2_zero_q;

    // Right shifts fold the dropped bits into sticky; left shifts lose nothing.
    always_comb begin
        shamt       = '0;
        norm_mag    = s1_mag_q;
        norm_sticky = s1_sticky_q;
        if (s1_lead_q > NormIdx) begin
            shamt       = s1_lead_q - NormIdx;
            norm_mag    = s1_mag_q >> shamt;
            norm_sticky = s1_sticky_q | (|(s1_mag_q & ~({MAG_WIDTH{1'b1}} << shamt)));
        end else if (s1_lead_q < NormIdx) begin
            shamt    = NormIdx - s1_lead_q;
            norm_mag = s1_mag_q << shamt;
        end
        norm_exp = {s1_exp_q[EXP_IN_WIDTH-1], s1_exp_q} + EW'(s1_lead_q) - NormExp;
    end

    // Stage 2 valid register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
        end else if (s1_adv) begin
            s2_valid_q <= s1_valid_q;
        end
    end

    // Stage 2 payload, captured when stage 1 hands over a beat.
    always_ff @(posedge clk) begin
        if (s1_valid_q && s1_adv) begin
            s2_sign_q   <= s1_sign_q;
            s2_exp_q    <= norm_exp;
            s2_mag_q    <= norm_mag;
            s2_sticky_q <= norm_sticky;
            s2_zero_q   <= s1_zero_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: round to nearest-even and pack
    // ------------------------------------------------------------------
    logic [FRAC_WIDTH-1:0] frac;
    logic                  guard_bit;
    logic                  round_bit;
    logic                  sticky_bit;
    logic                  round_up;
    logic [FRAC_WIDTH:0]   frac_sum;
    logic [EW-1:0]         exp_rnd;
    logic                  exp_low;
    logic [RW-1:0]         pack_result;
    logic                  pack_overflow;
    logic                  pack_underflow;
    logic                  pack_inexact;

    // Bits at and above NORM_POS are the hidden one (and an always-clear MSB).
    logic unused_norm_top;
    assign unused_norm_top = ^s2_mag_q[MAG_WIDTH-1:NORM_POS];

    // Round, then pick zero / underflow / overflow / normal encoding.
    always_comb begin
        frac       = s2_mag_q[NORM_POS-1 -: FRAC_WIDTH];
        guard_bit  = s2_mag_q[GuardPos];
        round_bit  = s2_mag_q[GuardPos-1];
        sticky_bit = (|s2_mag_q[GuardPos-2:0]) | s2_sticky_q;
        round_up   = guard_bit && (round_bit || sticky_bit || frac[0]);

        // A carry out of the fraction leaves zeros below it and bumps the exponent.
        frac_sum = {1'b0, frac} + {{FRAC_WIDTH{1'b0}}, round_up};
        exp_rnd  = s2_exp_q + {{(EW-1){1'b0}}, frac_sum[FRAC_WIDTH]};
        exp_low  = s2_exp_q[EW-1] || (s2_exp_q == '0);

        pack_result    = {s2_sign_q, exp_rnd[EXP_WIDTH-1:0], frac_sum[FRAC_WIDTH-1:0]};
        pack_overflow  = 1'b0;
        pack_underflow = 1'b0;
        pack_inexact   = guard_bit | round_bit | sticky_bit;

        if (s2_zero_q) begin
            pack_result  = {s2_sign_q, {(RW-1){1'b0}}};
            pack_inexact = 1'b0;
        end else if (exp_low) begin
            // No subnormal support: flush to signed zero.
            pack_result    = {s2_sign_q, {(RW-1){1'b0}}};
            pack_underflow = 1'b1;
            pack_inexact   = 1'b1;
        end else if (!exp_rnd[EW-1] && (exp_rnd >= ExpMax)) begin
            pack_result   = {s2_sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
            pack_overflow = 1'b1;
            pack_inexact  = 1'b1;
        end
    end

    // Stage 3 valid register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
        end else if (s2_adv) begin
            s3_valid_q <= s2_valid_q;
        end
    end

    // Output payload; holds while stalled and clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (s2_valid_q && s2_adv) begin
            out_result    <= pack_result;
            out_overflow  <= pack_overflow;
            out_underflow <= pack_underflow;
            out_inexact   <= pack_inexact;
        end
    end

    assign out_valid = s3_valid_q;

endmodule
